nios_led_sequencer: RTL and testbench
=====================================

# nios_led_sequencer

Avalon-MM slave that autonomously drives one board LED with static, continuous-blink or N-pulse burst patterns, so Nios firmware can signal EPCQ read/write/erase progress without bit-banging a PIO. Sits on the Nios data master alongside the other peripherals. Its single-bit `out_port` drives the LED pin.

## Interface
- `CNT_W`, default 32: width of the period/on-time counters; PERIOD and ON_TIME are CNT_W bits.
- `RESET_LEVEL`, default 1: `out_port` value in reset and after reset.
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: word address of the register.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data; combinational from `address`; zero-latency read.
- `out_port` out 1: LED drive; registered.

## Operation
- Registers:
  - 0 CTRL (rw): [1:0] MODE (0 STATIC, 1 BLINK, 2 BURST, 3 is treated as STATIC); [2] IDLE_LEVEL.
  - 1 PERIOD (rw): cycles per blink period. Values 0 and 1 are used as 2.
  - 2 ON_TIME (rw): high cycles per period.
  - 3 write: BURST_COUNT, bits [15:0].
  - 3 read: STATUS, with [0] BUSY, [1] DONE (sticky), [31:16] REMAINING pulses.
- A write is accepted on a clock edge with `chipselect && !write_n`. Reads are unconditional decodes of `address`.
- Reset values:
  - CTRL = {IDLE_LEVEL=RESET_LEVEL, MODE=STATIC}.
  - PERIOD = 2, ON_TIME = 1, BURST_COUNT = 0.
  - State IDLE, count 0, DONE = 0, `out_port` = RESET_LEVEL.
- States:
  - IDLE: `out_port` = IDLE_LEVEL.
  - RUN: count runs 0 to P-1 and wraps; `out_port` = (count < O).
  - DONE: `out_port` = IDLE_LEVEL.
- Every CTRL write restarts the sequencer:
  - Loads active P/O from PERIOD/ON_TIME.
  - Count = 0; REMAINING = BURST_COUNT; DONE cleared.
  - MODE STATIC → IDLE.
  - MODE BLINK or BURST → RUN.
  - BURST with BURST_COUNT = 0 → DONE directly, with DONE = 1.
- PERIOD/ON_TIME writes during RUN go to the shadow registers only. Active P/O reload at the next wrap (count P-1 → 0). This keeps the phase glitch-free.
- ON_TIME = 0: LED low for the whole period. ON_TIME ≥ P: LED high for the whole period.
- BURST: at each wrap REMAINING decrements. The wrap that takes it from 1 to 0 enters DONE and sets DONE.
- BUSY = (state == RUN).
- A BURST_COUNT write during RUN does not affect REMAINING until the next CTRL write.
- Arithmetic is unsigned. The count compare is CNT_W bits wide. REMAINING saturates at 0.

## Timing
- CTRL write at edge k: state, count and `out_port` update at edge k.
  - RUN: `out_port` = (O != 0) from edge k.
  - IDLE/DONE: `out_port` = IDLE_LEVEL from edge k.
- In RUN, `out_port` is high for exactly min(O,P) cycles and low for P − min(O,P) cycles per period, with period exactly P cycles.
- BURST of N: exactly N full periods after the CTRL edge. DONE state, DONE = 1 and `out_port` = IDLE_LEVEL all take effect at edge k + N·P.
- `readdata` reflects a register write from the cycle after the write edge.
- A CTRL write on the same edge as a wrap: the restart wins; no decrement occurs.
- A PERIOD write on the same edge as a wrap: the old shadow value is loaded; the new value applies from the next wrap.
- `reset_n` asserted mid-RUN: all state returns to reset values immediately (asynchronous). `out_port` = RESET_LEVEL.

## Structure
- Package `nios_led_seq_pkg` holds:
  - The mode enum (STATIC/BLINK/BURST).
  - The state enum (IDLE/RUN/DONE).
  - The register address constants (CTRL=0, PERIOD=1, ON_TIME=2, STATUS=3).
  - The STATUS/CTRL bit positions.
- Sub-module `nios_led_seq_timer`, parameterised by CNT_W:
  - Inputs: start, enable, P/O shadow values.
  - Outputs: count, wrap pulse, `phase_on`.
  - Owns the shadow-to-active reload.
- The top level holds the register file, the FSM, the REMAINING counter and the read mux.

## Test plan
- Reset only → `out_port` = 1; reads: CTRL = 0x4, PERIOD = 2, ON_TIME = 1, STATUS = 0.
- PERIOD = 10, ON_TIME = 3, CTRL = BLINK → `out_port` high 3 cycles then low 7, repeating. BUSY = 1. First high at the CTRL write edge.
- PERIOD = 4, ON_TIME = 2, BURST_COUNT = 3, CTRL = BURST | IDLE_LEVEL=0 → exactly 3 pulses. DONE = 1, BUSY = 0, `out_port` = 0 at edge k+12. REMAINING reads 3, 2, 1, 0 across the periods.
- BLINK with PERIOD = 8, ON_TIME = 4; write ON_TIME = 6 mid-period → the current period stays at 4/4; the next period is 6/2.
- Corners:
  - PERIOD = 0, ON_TIME = 0 → period 2, LED constantly low.
  - ON_TIME = 20, PERIOD = 5 → LED constantly high.
  - BURST with BURST_COUNT = 0 → DONE at the write edge.
- BURST running, `reset_n` pulsed low for 1 ns between edges → `out_port` = 1 immediately; all registers at reset values; STATUS = 0.

Source files
------------

// File: rtl/nios_led_seq_pkg.sv
// Purpose : shared types, register map and bit positions for the LED sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package nios_led_seq_pkg;

    // CTRL.MODE encodings; the value 3 is not named and behaves like STATIC.
    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_BURST  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Word addresses on the Avalon-MM slave.
    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_ON_TIME = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;  // write side is BURST_COUNT

    // CTRL bit positions.
    localparam int unsigned CTRL_MODE_LSB = 0;
    localparam int unsigned CTRL_MODE_MSB = 1;
    localparam int unsigned CTRL_IDLE_BIT = 2;

    // STATUS bit positions.
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_REM_LSB  = 16;
    localparam int unsigned STAT_REM_MSB  = 31;

    // BURST_COUNT / REMAINING width.
    localparam int unsigned BURST_W = 16;

    function automatic logic [31:0] pack_status(input logic               busy,
                                                input logic               done,
                                                input logic [BURST_W-1:0] rem);
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY_BIT]               = busy;
        w[STAT_DONE_BIT]               = done;
        w[STAT_REM_MSB:STAT_REM_LSB]   = rem;
        return w;
    endfunction

endpackage

// File: rtl/nios_led_seq_timer.sv
// Purpose : period/on-time counter with shadow-to-active reload at restart or wrap.
// Latency : count/wrap registered; phase_on is the LED level for the cycle after the coming edge.
// Backpressure: none; counts every cycle while enabled.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start                        restart: count <- 0, active P/O <- shadow
//   enable                       advance the count this cycle
//   period_shadow, on_shadow     programmed PERIOD / ON_TIME values
//   count                        current position within the period
//   wrap                         high in the cycle whose edge takes count P-1 -> 0
//   phase_on                     (next count < next active on-time)
module nios_led_seq_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_shadow,
    input  logic [CNT_W-1:0] on_shadow,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             phase_on
);

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] period_act_q;
    logic [CNT_W-1:0] on_act_q;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] period_act_d;
    logic [CNT_W-1:0] on_act_d;

    // Periods of 0 or 1 cannot toggle the LED, so they are stretched to 2.
    assign period_eff = (period_shadow < MIN_PERIOD) ? MIN_PERIOD : period_shadow;

    // A restart takes priority over a wrap on the same edge.
    assign wrap = enable && !start && (count == (period_act_q - ONE));

    always_comb begin
        count_d      = count;
        period_act_d = period_act_q;
        on_act_d     = on_act_q;
        if (start || wrap) begin
            // Active values only change at a period boundary, so a
            // mid-period PERIOD/ON_TIME write never cuts a pulse short.
            count_d      = '0;
            period_act_d = period_eff;
            on_act_d     = on_shadow;
        end else if (enable) begin
            count_d = count + ONE;
        end
    end

    // Computed from next-state values so the registered LED output
    // changes on the same edge as the count.
    assign phase_on = (count_d < on_act_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            period_act_q <= MIN_PERIOD;
            on_act_q     <= ONE;
        end else begin
            count        <= count_d;
            period_act_q <= period_act_d;
            on_act_q     <= on_act_d;
        end
    end

endmodule

// File: rtl/nios_led_sequencer.sv
// Purpose : Avalon-MM slave driving one LED with static, blink or N-pulse burst patterns.
// Latency : zero-latency reads (combinational readdata); writes and out_port take effect at the write edge.
// Backpressure: none; every access completes in one cycle (no waitrequest).
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   address[1:0]         0 CTRL, 1 PERIOD, 2 ON_TIME, 3 BURST_COUNT(w)/STATUS(r)
//   chipselect, write_n  write accepted on chipselect && !write_n
//   writedata[31:0]      write data
//   readdata[31:0]       combinational decode of address
//   out_port             registered LED drive
module nios_led_sequencer
    import nios_led_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,   // must not exceed the 32-bit bus
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port
);

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    logic [1:0]         ctrl_mode_q;
    logic               ctrl_idle_q;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   on_time_q;
    logic [BURST_W-1:0] burst_count_q;

    logic wr_en;
    logic ctrl_wr;

    assign wr_en   = chipselect && !write_n;
    assign ctrl_wr = wr_en && (address == ADDR_CTRL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_mode_q   <= MODE_STATIC;
            ctrl_idle_q   <= RESET_LEVEL;
            period_q      <= CNT_W'(2);
            on_time_q     <= CNT_W'(1);
            burst_count_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    ctrl_mode_q <= writedata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                    ctrl_idle_q <= writedata[CTRL_IDLE_BIT];
                end
                ADDR_PERIOD:  period_q      <= writedata[CNT_W-1:0];
                ADDR_ON_TIME: on_time_q     <= writedata[CNT_W-1:0];
                default:      burst_count_q <= writedata[BURST_W-1:0];
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Timer
    // ---------------------------------------------------------------
    state_e             state_q;
    state_e             state_d;
    logic               timer_wrap;
    logic               timer_phase_on;
    logic [CNT_W-1:0]   unused_timer_count;  // position is not needed by the control path

    nios_led_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (ctrl_wr),
        .enable        (state_q == ST_RUN),
        .period_shadow (period_q),
        .on_shadow     (on_time_q),
        .count         (unused_timer_count),
        .wrap          (timer_wrap),
        .phase_on      (timer_phase_on)
    );

    // ---------------------------------------------------------------
    // Sequencer FSM, REMAINING counter and LED register
    // ---------------------------------------------------------------
    logic [BURST_W-1:0] remaining_q;
    logic [BURST_W-1:0] remaining_d;
    logic               done_q;
    logic               done_d;
    logic               idle_level_d;
    logic               out_port_d;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        done_d       = done_q;
        idle_level_d = ctrl_wr ? writedata[CTRL_IDLE_BIT] : ctrl_idle_q;

        if (ctrl_wr) begin
            // Every CTRL write restarts; it also masks a coincident wrap,
            // so no decrement happens on that edge.
            remaining_d = burst_count_q;
            done_d      = 1'b0;
            case (writedata[CTRL_MODE_MSB:CTRL_MODE_LSB])
                MODE_BLINK: state_d = ST_RUN;
                MODE_BURST: begin
                    if (burst_count_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end else if ((state_q == ST_RUN) && timer_wrap && (ctrl_mode_q == MODE_BURST)) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - BURST_W'(1);
            end
            if (remaining_q == BURST_W'(1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end

        out_port_d = (state_d == ST_RUN) ? timer_phase_on : idle_level_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
            out_port    <= RESET_LEVEL;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            out_port    <= out_port_d;
        end
    end

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_mode_q;
                readdata[CTRL_IDLE_BIT]               = ctrl_idle_q;
            end
            ADDR_PERIOD:  readdata = 32'(period_q);
            ADDR_ON_TIME: readdata = 32'(on_time_q);
            default:      readdata = pack_status(state_q == ST_RUN, done_q, remaining_q);
        endcase
    end

endmodule

// File: tb/tb_nios_led_sequencer.sv
module tb_nios_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;

    nios_led_sequencer #(
        .CNT_W       (32),
        .RESET_LEVEL (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: the LED waveform of the current period is held as
    // a queue of levels, built from the programmed values whenever a new
    // period begins and consumed one entry per clock.
    // ---------------------------------------------------------------
    logic [1:0]  m_mode;
    logic        m_idle;
    logic [31:0] m_period;
    logic [31:0] m_on;
    logic [15:0] m_burst;
    logic [15:0] m_rem;
    bit          m_run;
    bit          m_done;
    logic        m_out;
    bit          m_q[$];

    task automatic model_reset();
        m_mode = 2'd0; m_idle = 1'b1; m_period = 32'd2; m_on = 32'd1;
        m_burst = 16'd0; m_rem = 16'd0; m_run = 0; m_done = 0; m_out = 1'b1;
        m_q.delete();
    endtask

    task automatic fill_period();
        longint unsigned p;
        longint unsigned h;
        p = (m_period < 2) ? 2 : m_period;
        h = (m_on < p) ? m_on : p;
        for (longint unsigned i = 0; i < p; i++) m_q.push_back(i < h);
    endtask

    // One clock edge; w/a/d describe the bus write presented at it.
    task automatic model_edge(input bit w, input logic [1:0] a, input logic [31:0] d);
        if (w && a == 2'd0) begin
            m_mode = d[1:0];
            m_idle = d[2];
            m_q.delete();
            m_rem  = m_burst;
            m_done = 0;
            if (m_mode == 2'd1 || (m_mode == 2'd2 && m_burst != 0)) begin
                m_run = 1;
                fill_period();
            end else begin
                m_run = 0;
                if (m_mode == 2'd2) m_done = 1;
            end
        end else if (m_run && m_q.size() == 0) begin
            if (m_mode == 2'd2) begin
                m_rem = m_rem - 16'd1;
                if (m_rem == 0) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
            if (m_run) fill_period();
        end
        m_out = m_run ? m_q.pop_front() : m_idle;
        // Register writes land after the sequencer step: a refill on
        // this edge still sees the previous programmed values.
        if (w) begin
            case (a)
                2'd1:    m_period = d;
                2'd2:    m_on     = d;
                2'd3:    m_burst  = d[15:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] ra);
        case (ra)
            2'd0:    return {29'd0, m_idle, m_mode};
            2'd1:    return m_period;
            2'd2:    return m_on;
            default: return {m_rem, 14'd0, m_done, m_run};
        endcase
    endfunction

    // Drive one cycle, step the model, then check out_port and one read.
    task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d,
                        input logic [1:0] ra);
        if (w) begin
            chipselect = 1'b1; write_n = 1'b0;
        end else begin
            case ($urandom_range(0, 2))
                0:       begin chipselect = 1'b0; write_n = 1'b1; end
                1:       begin chipselect = 1'b1; write_n = 1'b1; end
                default: begin chipselect = 1'b0; write_n = 1'b0; end
            endcase
        end
        address   = a;
        writedata = d;
        @(posedge clk);
        #1;
        model_edge(w, a, d);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ra;
        writedata  = $urandom;
        #1;
        chk("out_port", {31'd0, out_port}, {31'd0, m_out});
        chk("readdata", readdata, model_read(ra));
    endtask

    task automatic idle_tick(input logic [1:0] ra);
        tick(1'b0, 2'($urandom_range(0, 3)), $urandom, ra);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        logic        exp_led;
    } wr_vec_t;

    rd_vec_t rst_tbl[4];
    wr_vec_t wr_tbl[7];

    task automatic check_reset_table();
        for (int i = 0; i < 4; i++) begin
            address = rst_tbl[i].addr;
            #1;
            chk($sformatf("reset_read_%0d", i), readdata, rst_tbl[i].exp);
        end
    endtask

    logic [19:0] pat20;
    logic [15:0] pat16;
    logic        any_hi;
    logic        all_hi;
    int          rises;
    logic        prev;

    initial begin
        rst_tbl[0] = '{2'd0, 32'h0000_0004};
        rst_tbl[1] = '{2'd1, 32'h0000_0002};
        rst_tbl[2] = '{2'd2, 32'h0000_0001};
        rst_tbl[3] = '{2'd3, 32'h0000_0000};

        wr_tbl[0] = '{2'd1, 32'h0000_1234, 2'd1, 32'h0000_1234, 1'b1};
        wr_tbl[1] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF, 1'b1};
        wr_tbl[2] = '{2'd0, 32'h0000_0003, 2'd0, 32'h0000_0003, 1'b0};
        wr_tbl[3] = '{2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0007, 1'b1};
        wr_tbl[4] = '{2'd3, 32'hABCD_0005, 2'd3, 32'h0000_0000, 1'b1};
        wr_tbl[5] = '{2'd0, 32'h0000_0004, 2'd3, 32'h0005_0000, 1'b1};
        wr_tbl[6] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000, 1'b0};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_port", {31'd0, out_port}, 32'd1);
        reset_n = 1'b1;
        check_reset_table();

        // Register write / readback table.
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, wr_tbl[i].waddr, wr_tbl[i].wdata, wr_tbl[i].raddr);
            chk($sformatf("table_read_%0d", i), readdata, wr_tbl[i].exp);
            chk($sformatf("table_led_%0d", i), {31'd0, out_port}, {31'd0, wr_tbl[i].exp_led});
        end

        // BLINK 10/3: first high cycle at the CTRL edge.
        tick(1'b1, 2'd1, 32'd10, 2'd3);
        tick(1'b1, 2'd2, 32'd3, 2'd3);
        tick(1'b1, 2'd0, 32'd1, 2'd3);
        pat20[19] = out_port;
        chk("blink_busy", readdata & 32'h3, 32'h1);
        for (int i = 1; i < 20; i++) begin
            idle_tick(2'd3);
            pat20[19-i] = out_port;
        end
        chk("blink_pattern", {12'd0, pat20}, {12'd0, 20'b1110000000_1110000000});

        // BURST of 3 on 4/2 with idle level 0; done at k+12.
        tick(1'b1, 2'd1, 32'd4, 2'd3);
        tick(1'b1, 2'd2, 32'd2, 2'd3);
        tick(1'b1, 2'd3, 32'd3, 2'd3);
        tick(1'b1, 2'd0, 32'd2, 2'd3);
        chk("burst_rem_k0", readdata, 32'h0003_0001);
        rises = 1; prev = out_port;
        for (int j = 1; j <= 12; j++) begin
            idle_tick(2'd3);
            if (out_port && !prev) rises++;
            prev = out_port;
            if (j == 4)  chk("burst_rem_k4",  readdata, 32'h0002_0001);
            if (j == 8)  chk("burst_rem_k8",  readdata, 32'h0001_0001);
            if (j == 11) chk("burst_led_k11", {31'd0, out_port}, 32'd0);
        end
        chk("burst_status_done", readdata, 32'h0000_0002);
        chk("burst_led_done", {31'd0, out_port}, 32'd0);
        chk("burst_pulses", rises, 3);

        // Mid-period ON_TIME change only affects the following period.
        tick(1'b1, 2'd1, 32'd8, 2'd0);
        tick(1'b1, 2'd2, 32'd4, 2'd0);
        tick(1'b1, 2'd0, 32'd1, 2'd0);
        pat16[15] = out_port;
        idle_tick(2'd2);
        pat16[14] = out_port;
        tick(1'b1, 2'd2, 32'd6, 2'd2);
        pat16[13] = out_port;
        for (int i = 3; i < 16; i++) begin
            idle_tick(2'd3);
            pat16[15-i] = out_port;
        end
        chk("shadow_pattern", {16'd0, pat16}, {16'd0, 16'b11110000_11111100});

        // PERIOD=0, ON_TIME=0: LED stays low.
        tick(1'b1, 2'd1, 32'd0, 2'd1);
        tick(1'b1, 2'd2, 32'd0, 2'd2);
        tick(1'b1, 2'd0, 32'd5, 2'd3);
        any_hi = out_port;
        for (int i = 0; i < 6; i++) begin
            idle_tick(2'd3);
            any_hi |= out_port;
        end
        chk("p0_o0_low", {31'd0, any_hi}, 32'd0);

        // ON_TIME beyond PERIOD: LED stays high.
        tick(1'b1, 2'd2, 32'd20, 2'd3);
        tick(1'b1, 2'd1, 32'd5, 2'd3);
        tick(1'b1, 2'd0, 32'd1, 2'd3);
        all_hi = out_port;
        for (int i = 0; i < 12; i++) begin
            idle_tick(2'd3);
            all_hi &= out_port;
        end
        chk("o20_p5_high", {31'd0, all_hi}, 32'd1);

        // BURST with BURST_COUNT 0 finishes at the write edge.
        tick(1'b1, 2'd3, 32'd0, 2'd3);
        tick(1'b1, 2'd0, 32'd2, 2'd3);
        chk("burst0_status", readdata, 32'h0000_0002);
        chk("burst0_led", {31'd0, out_port}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        tick(1'b1, 2'd1, 32'd3, 2'd3);
        tick(1'b1, 2'd2, 32'd1, 2'd3);
        tick(1'b1, 2'd3, 32'd4, 2'd3);
        tick(1'b1, 2'd0, 32'd2, 2'd3);
        for (int i = 0; i < 4; i++) idle_tick(2'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_led", {31'd0, out_port}, 32'd1);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_edge(1'b0, 2'd0, 32'd0);
        check_reset_table();

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                2'd1:    d = 32'($urandom_range(0, 12));
                2'd2:    d = 32'($urandom_range(0, 14));
                default: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
            endcase
            if ($urandom_range(0, 4) == 0) tick(1'b1, a, d, 2'($urandom_range(0, 3)));
            else                           tick(1'b0, a, d, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
